// File: rtl/cmplx_square_accel.sv
// cmplx_square_accel
//   Avalon-MM slave that squares a signed complex operand (a_re + j*a_im):
//      y_re = re^2 - im^2,  y_im = 2*re*im (saturated to 0x7FFFFFFF on overflow)
//   using one shared signed OP_W x OP_W multiplier over three cycles.
//
//   Register map (word addresses):
//      0 CTRL   W: bit0 start, bit1 clr_done, bit2 irq_en   R: bit2 irq_en
//      1 STATUS R: bit0 busy, bit1 done, bit2 ovf
//      2 A_RE   RW (OP_W bits, read sign-extended)
//      3 A_IM   RW
//      4 Y_RE   R
//      5 Y_IM   R
//      6-7      read 0
//
//   Timing: a start write sampled at edge k moves the FSM to S_RR at edge k.
//   A read sampled at edge k+1 therefore sees busy=1, and the read sampled
//   at edge k+5 is the first to see done=1 with the new results.
//
// Ports
//   clk_clk        clock, all logic on the rising edge
//   reset_reset    asynchronous active-high reset
//   avs_address    word address
//   avs_write      write strobe, avs_writedata write data
//   avs_read       read strobe, avs_readdata registered read data (latency 1)
//   irq            registered level interrupt = done AND irq_en
module cmplx_square_accel #(
   parameter int OP_W = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [2:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic        irq
);

   localparam int PW = 2 * OP_W;
   // Wide enough to hold 2*re*im exactly and to compare against 32-bit limits.
   localparam int XW = (PW > 32) ? PW + 2 : 34;
   localparam logic signed [XW-1:0] Y_MAX = $signed({{(XW-31){1'b0}}, {31{1'b1}}});
   localparam logic signed [XW-1:0] Y_MIN = $signed({{(XW-31){1'b1}}, {31{1'b0}}});

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S_RR  = 3'd1,
      S_II  = 3'd2,
      S_RI  = 3'd3,
      S_FIN = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic                   irq_en_q, irq_en_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   irq_q, irq_d;
   logic        [OP_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
   logic        [OP_W-1:0] op_re_q, op_re_d, op_im_q, op_im_d;
   logic signed [PW-1:0]   rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
   logic        [31:0]     y_re_q, y_re_d, y_im_q, y_im_d;
   logic        [31:0]     rdata_q, rdata_d;

   logic signed [OP_W-1:0] mul_a, mul_b;
   logic signed [PW-1:0]   mul_p;
   logic signed [XW-1:0]   y_re_x, y_im_x;
   logic                   wr_ctrl, start_ok, busy;
   logic                   unused_bits;

   assign unused_bits = ^{avs_writedata[31:OP_W], y_re_x[XW-1:32]};

   // Operand select for the single shared multiplier.
   always_comb begin
      mul_a = $signed(op_re_q);
      mul_b = $signed(op_re_q);
      case (state_q)
         S_II:    begin mul_a = $signed(op_im_q); mul_b = $signed(op_im_q); end
         S_RI:    begin mul_a = $signed(op_re_q); mul_b = $signed(op_im_q); end
         default: begin mul_a = $signed(op_re_q); mul_b = $signed(op_re_q); end
      endcase
   end

   assign mul_p  = mul_a * mul_b;
   assign y_re_x = $signed({{(XW-PW){rr_q[PW-1]}}, rr_q}) - $signed({{(XW-PW){ii_q[PW-1]}}, ii_q});
   assign y_im_x = $signed({{(XW-PW){ri_q[PW-1]}}, ri_q}) <<< 1;

   // Next-state logic: bus writes, FSM sequencing, result capture, read mux.
   always_comb begin
      state_d  = state_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      a_re_d   = a_re_q;
      a_im_d   = a_im_q;
      op_re_d  = op_re_q;
      op_im_d  = op_im_q;
      rr_d     = rr_q;
      ii_d     = ii_q;
      ri_d     = ri_q;
      y_re_d   = y_re_q;
      y_im_d   = y_im_q;
      rdata_d  = rdata_q;

      busy     = (state_q != IDLE);
      wr_ctrl  = avs_write && (avs_address == 3'd0);
      start_ok = wr_ctrl && avs_writedata[0] && (state_q == IDLE);

      if (avs_write) begin
         case (avs_address)
            3'd0:    irq_en_d = avs_writedata[2];
            3'd2:    a_re_d   = avs_writedata[OP_W-1:0];
            3'd3:    a_im_d   = avs_writedata[OP_W-1:0];
            default: a_re_d   = a_re_q;  // read-only addresses ignore writes
         endcase
      end else begin
         a_re_d = a_re_q;
      end

      // clr_done is applied before the FSM so an S_FIN completion on the
      // same edge overrides it.
      if (wr_ctrl && avs_writedata[1]) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = S_RR;
               op_re_d = a_re_q;
               op_im_d = a_im_q;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         S_RR: begin
            rr_d    = mul_p;
            state_d = S_II;
         end
         S_II: begin
            ii_d    = mul_p;
            state_d = S_RI;
         end
         S_RI: begin
            ri_d    = mul_p;
            state_d = S_FIN;
         end
         S_FIN: begin
            y_re_d = y_re_x[31:0];
            if (y_im_x > Y_MAX) begin
               y_im_d = 32'h7FFF_FFFF;
               ovf_d  = 1'b1;
            end else if (y_im_x < Y_MIN) begin
               y_im_d = 32'h8000_0000;
               ovf_d  = 1'b1;
            end else begin
               y_im_d = y_im_x[31:0];
               ovf_d  = 1'b0;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      irq_d = done_q & irq_en_q;

      if (avs_read) begin
         case (avs_address)
            3'd0:    rdata_d = {29'd0, irq_en_q, 2'd0};
            3'd1:    rdata_d = {29'd0, ovf_q, done_q, busy};
            3'd2:    rdata_d = {{(32-OP_W){a_re_q[OP_W-1]}}, a_re_q};
            3'd3:    rdata_d = {{(32-OP_W){a_im_q[OP_W-1]}}, a_im_q};
            3'd4:    rdata_d = y_re_q;
            3'd5:    rdata_d = y_im_q;
            default: rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q  <= IDLE;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         a_re_q   <= '0;
         a_im_q   <= '0;
         op_re_q  <= '0;
         op_im_q  <= '0;
         rr_q     <= '0;
         ii_q     <= '0;
         ri_q     <= '0;
         y_re_q   <= 32'd0;
         y_im_q   <= 32'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
         a_re_q   <= a_re_d;
         a_im_q   <= a_im_d;
         op_re_q  <= op_re_d;
         op_im_q  <= op_im_d;
         rr_q     <= rr_d;
         ii_q     <= ii_d;
         ri_q     <= ri_d;
         y_re_q   <= y_re_d;
         y_im_q   <= y_im_d;
         rdata_q  <= rdata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_cmplx_square_accel.sv
// Directed bench for cmplx_square_accel. Each bus access occupies exactly one
// rising edge: inputs are driven on the falling edge, sampled on the next
// rising edge, and read data is taken on the following falling edge.
// Expected results come from a behavioural model pushed to a scoreboard
// queue when a start is issued and popped when done is observed.
module tb_cmplx_square_accel;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic [2:0]  avs_address = 3'd0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [64:0] exp_q[$];   // {ovf, y_re, y_im}

   cmplx_square_accel #(.OP_W(16)) dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .irq           (irq)
   );

   always #5 clk_clk = ~clk_clk;

   function automatic logic [64:0] model(input int re, input int im);
      longint yr, yi;
      logic   ov;
      yr = longint'(re) * longint'(re) - longint'(im) * longint'(im);
      yi = longint'(2) * longint'(re) * longint'(im);
      ov = (yi > longint'(2147483647));
      if (ov) yi = longint'(2147483647);
      return {ov, yr[31:0], yi[31:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk_clk);
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk_clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic go(input logic [31:0] ctrl, input int re, input int im);
      wr(3'd0, ctrl);
      exp_q.push_back(model(re, im));
   endtask

   // Poll STATUS until done (bounded), then compare results with the scoreboard.
   task automatic collect(input string tag, output int polls);
      logic [31:0] s, yr, yi;
      logic [64:0] e;
      bit seen;
      seen = 1'b0; polls = 0; s = 32'd0;
      for (int i = 0; i < 30 && !seen; i++) begin
         rd(3'd1, s);
         polls++;
         if (s[1]) seen = 1'b1;
      end
      check({tag, " done seen"}, {31'd0, seen}, 32'd1);
      rd(3'd4, yr);
      rd(3'd5, yi);
      e = exp_q.pop_front();
      check({tag, " y_re"}, yr, e[63:32]);
      check({tag, " y_im"}, yi, e[31:0]);
      check({tag, " ovf"}, {31'd0, s[2]}, {31'd0, e[64]});
   endtask

   initial begin
      logic [31:0] d;
      int polls;
      int bad;

      // Reset state
      #1;
      check("reset readdata", avs_readdata, 32'd0);
      check("reset irq", {31'd0, irq}, 32'd0);
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset = 1'b0;
      rd(3'd1, d); check("post-reset status", d, 32'd0);
      rd(3'd4, d); check("post-reset y_re", d, 32'd0);
      rd(3'd0, d); check("post-reset ctrl", d, 32'd0);

      // (3,4): busy on the four reads after the start, done on the fifth
      wr(3'd2, 32'd3);
      wr(3'd3, 32'd4);
      go(32'd1, 3, 4);
      for (int i = 1; i <= 4; i++) begin
         rd(3'd1, d);
         check($sformatf("t1 busy k+%0d", i), d, 32'd1);
      end
      collect("t1", polls);
      check("t1 done latency", polls, 32'd1);
      check("t1 irq disabled", {31'd0, irq}, 32'd0);

      // Overflow corner and sign extension of A_RE
      wr(3'd2, 32'h0000_8000);
      rd(3'd2, d); check("a_re sign ext", d, 32'hFFFF_8000);
      wr(3'd3, 32'h0000_8000);
      go(32'd1, -32768, -32768);
      collect("t2a", polls);
      wr(3'd3, 32'h0000_7FFF);
      go(32'd1, -32768, 32767);
      rd(3'd1, d); check("t2b start clears done/ovf", d, 32'd1);
      collect("t2b", polls);

      // Start while busy is ignored, operand change only affects next op
      wr(3'd2, 32'd1);
      wr(3'd3, 32'd1);
      go(32'd1, 1, 1);
      wr(3'd2, 32'd5);
      wr(3'd0, 32'd1);
      rd(3'd1, d); check("t3 busy k+3", d, 32'd1);
      rd(3'd1, d); check("t3 busy k+4", d, 32'd1);
      collect("t3", polls);
      check("t3 done latency", polls, 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         rd(3'd1, d);
         if (d != 32'd2) bad++;
      end
      check("t3 no restart", bad, 32'd0);
      rd(3'd2, d); check("t3 a_re readback", d, 32'd5);
      go(32'd1, 5, 1);
      collect("t3b", polls);

      // irq, and clr_done coinciding with completion
      wr(3'd0, 32'd6);
      rd(3'd0, d); check("t4 ctrl irq_en", d, 32'd4);
      wr(3'd2, 32'd2);
      wr(3'd3, 32'd0);
      go(32'd5, 2, 0);
      for (int i = 1; i <= 3; i++) rd(3'd1, d);
      wr(3'd0, 32'd6);
      check("t4 irq lags done", {31'd0, irq}, 32'd0);
      collect("t4", polls);
      check("t4 completion wins", polls, 32'd1);
      check("t4 irq set", {31'd0, irq}, 32'd1);
      wr(3'd0, 32'd6);
      check("t4 irq lags clear", {31'd0, irq}, 32'd1);
      rd(3'd1, d); check("t4 status cleared", d, 32'd0);
      check("t4 irq cleared", {31'd0, irq}, 32'd0);

      // Reset mid-operation
      wr(3'd2, 32'd3);
      wr(3'd3, 32'd4);
      go(32'd5, 3, 4);
      rd(3'd1, d); check("t5 busy before reset", d, 32'd1);
      reset_reset = 1'b1;
      #1;
      check("t5 async readdata", avs_readdata, 32'd0);
      check("t5 async irq", {31'd0, irq}, 32'd0);
      exp_q.delete();
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset = 1'b0;
      rd(3'd2, d); check("t5 a_re zero", d, 32'd0);
      rd(3'd3, d); check("t5 a_im zero", d, 32'd0);
      rd(3'd4, d); check("t5 y_re zero", d, 32'd0);
      rd(3'd5, d); check("t5 y_im zero", d, 32'd0);
      rd(3'd0, d); check("t5 irq_en zero", d, 32'd0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         rd(3'd1, d);
         if (d != 32'd0) bad++;
      end
      check("t5 done never", bad, 32'd0);
      wr(3'd3, 32'd7);
      go(32'd1, 0, 7);
      collect("t5b", polls);

      // Unmapped reads, writes to read-only registers
      rd(3'd4, d);
      rd(3'd6, d); check("addr6 zero", d, 32'd0);
      rd(3'd4, d);
      rd(3'd7, d); check("addr7 zero", d, 32'd0);
      wr(3'd4, 32'h0000_1234);
      wr(3'd5, 32'h0000_5678);
      wr(3'd1, 32'd7);
      rd(3'd4, d); check("y_re write ignored", d, 32'hFFFF_FFCF);
      rd(3'd5, d); check("y_im write ignored", d, 32'd0);
      rd(3'd1, d); check("status write ignored", d, 32'd2);

      // start together with clr_done in IDLE
      go(32'd3, 0, 7);
      rd(3'd1, d); check("t7 start+clr busy", d, 32'd1);
      collect("t7", polls);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmplx_square_accel.md
CMPLX_SQUARE_ACCEL -- requirements
Module: cmplx_square_accel

Interface
REQ-001 The block SHALL have parameter OP_W, default 16, giving the signed operand width; all values below assume OP_W=16.
REQ-002 The block SHALL have port clk_clk, input, 1 bit: single clock; all logic rising-edge.
REQ-003 The block SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port avs_address, input, 3 bits: Avalon-MM word address.
REQ-005 The block SHALL have port avs_write, input, 1 bit: write strobe.
REQ-006 The block SHALL have port avs_writedata, input, 32 bits: write data.
REQ-007 The block SHALL have port avs_read, input, 1 bit: read strobe.
REQ-008 The block SHALL have port avs_readdata, output, 32 bits: registered read data.
REQ-009 The block SHALL have port irq, output, 1 bit: level interrupt to the HPS.

Function
REQ-010 The register map SHALL be: 0 CTRL (W: bit0 start, bit1 clr_done, bit2 irq_en; R: bit2 irq_en, others 0); 1 STATUS (R: bit0 busy, bit1 done, bit2 ovf); 2 A_RE (RW, signed OP_W in low bits); 3 A_IM (RW); 4 Y_RE (R, signed 32); 5 Y_IM (R, signed 32); 6-7 read 0.
REQ-011 Reads SHALL have fixed latency 1: avs_readdata is valid the cycle after avs_read; writes to read-only addresses SHALL be ignored.
REQ-012 A_RE/A_IM writes SHALL take only avs_writedata[OP_W-1:0]; reads SHALL return them sign-extended to 32 bits.
REQ-013 The FSM SHALL have states IDLE, S_RR, S_II, S_RI, S_FIN; IDLE->S_RR on CTRL write with bit0=1; S_RR->S_II->S_RI->S_FIN->IDLE one state per cycle, unconditionally.
REQ-014 On accepting start, operands SHALL be snapshotted from A_RE/A_IM; later A_RE/A_IM writes SHALL affect only the next operation.
REQ-015 A single shared signed OP_W x OP_W multiplier SHALL compute re*re in S_RR, im*im in S_II, re*im in S_RI; S_FIN combines.
REQ-016 Y_RE SHALL equal re^2 - im^2 (always fits 32 bits); Y_IM SHALL equal 2*re*im, saturated to 0x7FFFFFFF with ovf=1 when the exact value exceeds 2^31-1 (only re=im=-32768); otherwise ovf=0.
REQ-017 If the start write occurs at edge k, busy SHALL read 1 from edge k+1 and done=1, busy=0, Y_RE/Y_IM/ovf updated at edge k+5.
REQ-018 A start while busy=1 SHALL be ignored: no restart, no operand snapshot, no error flag.
REQ-019 Accepting a start SHALL clear done and ovf at edge k+1.
REQ-020 clr_done SHALL clear done; if clr_done and the S_FIN completion coincide, done SHALL end at 1 (completion wins).
REQ-021 A CTRL write with both start=1 and clr_done=1 in IDLE SHALL start the operation (done cleared).
REQ-022 irq SHALL be registered and equal done AND irq_en, one cycle after either changes.
REQ-023 Y_RE/Y_IM SHALL hold their last results until the next completion.

Reset
REQ-024 On reset_reset=1, immediately and asynchronously: FSM=IDLE, busy=0, done=0, ovf=0, irq_en=0, irq=0, A_RE=A_IM=0, Y_RE=Y_IM=0, avs_readdata=0.
REQ-025 Reset asserted mid-operation SHALL abort it with no result update; after release the block SHALL accept a new start on the first write.

Verification
REQ-026 Write A_RE=3, A_IM=4, start at edge k -> STATUS busy=1 at k+1..k+4; at k+5 done=1, Y_RE=0xFFFFFFF9 (-7), Y_IM=24, ovf=0.
REQ-027 A_RE=-32768, A_IM=-32768, start -> Y_RE=0, Y_IM=0x7FFFFFFF, ovf=1; A_RE=-32768, A_IM=32767 -> Y_IM=0x80010000, ovf=0.
REQ-028 Start with (1,1), write A_RE=5 and a second start at k+2 -> result Y_RE=0, Y_IM=2; second start ignored; done at k+5 only.
REQ-029 irq_en=1, run (2,0) -> irq=1 one cycle after done (Y_RE=4, Y_IM=0); clr_done at the same edge as S_FIN completion -> done stays 1; later clr_done -> done=0, irq=0 next cycle.
REQ-030 Assert reset_reset at k+2 of an operation -> all registers zero, done never asserts; after release start with (0,7) -> Y_RE=0xFFFFFFCF (-49), Y_IM=0.
REQ-031 Read address 6 and 7 -> 0; write to Y_RE address -> value unchanged.
